kb_ascii_ctrl: RTL and testbench

- Sequences the PS/2 scancode-to-ASCII lookup table.
- Consumes raw scancode bytes from the PS/2 receiver and tracks the protocol states for make, break (F0) and extended (E0) codes.
- Maintains Shift and Caps Lock state and drives the lookup with each accepted make code.
- Case-adjusts the returned character and buffers it in a small FIFO for the display/console stage, using a valid/ready handshake.

---
 rtl/kb_ascii_ctrl.sv | 139 +++++++++++++
 tb/tb_kb_ascii_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_ascii_ctrl.sv
// PS/2 scancode sequencer: make/break/extended decode, Shift/Caps tracking,
// case-adjusted lookup result into a show-ahead FIFO. Optional KB_TYPEMATIC_FILTER_EN.
module kb_ascii_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  SHIFT_L    = 8'h12,
  parameter logic [7:0]  SHIFT_R    = 8'h59,
  parameter logic [7:0]  CAPS       = 8'h58
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_valid,
  output logic [7:0] lut_code,
  input  logic [7:0] lut_ascii,
  output logic [7:0] ascii_data,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       shift_active,
  output logic       caps_active,
  output logic [7:0] key_count,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

  state_e     state_q;
  logic       shl_q, shr_q, caps_q, pend_q;
  logic [7:0] code_q;
  logic       repeat_c;

`ifdef KB_TYPEMATIC_FILTER_EN
  logic [7:0] last_make_q;
  assign repeat_c = (kb_data == last_make_q);
`else
  assign repeat_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shl_q   <= 1'b0;
      shr_q   <= 1'b0;
      caps_q  <= 1'b0;
      pend_q  <= 1'b0;
      code_q  <= '0;
`ifdef KB_TYPEMATIC_FILTER_EN
      last_make_q <= '0;
`endif
    end else begin
      pend_q <= 1'b0;
      if (kb_valid) begin
        unique case (state_q)
          IDLE: begin
            if (kb_data == 8'hF0) begin
              state_q <= BRK;
            end else if (kb_data == 8'hE0) begin
              state_q <= EXT;
            end else if (!repeat_c) begin
`ifdef KB_TYPEMATIC_FILTER_EN
              last_make_q <= kb_data;
`endif
              if (kb_data == SHIFT_L) begin
                shl_q <= 1'b1;
              end else if (kb_data == SHIFT_R) begin
                shr_q <= 1'b1;
              end else if (kb_data == CAPS) begin
                caps_q <= ~caps_q;
              end else begin
                code_q <= kb_data;
                pend_q <= 1'b1;
              end
            end
          end
          EXT:     state_q <= (kb_data == 8'hF0) ? EXT_BRK : IDLE;
          BRK: begin
            if (kb_data == SHIFT_L) shl_q <= 1'b0;
            if (kb_data == SHIFT_R) shr_q <= 1'b0;
`ifdef KB_TYPEMATIC_FILTER_EN
            // releasing the held key re-arms it for the next press
            if (repeat_c) last_make_q <= '0;
`endif
            state_q <= IDLE;
          end
          EXT_BRK: state_q <= IDLE;
        endcase
      end
    end
  end

  assign lut_code     = code_q;
  assign shift_active = shl_q | shr_q;
  assign caps_active  = caps_q;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [7:0]  char_c;
  logic        push_req_c, push_c, pop_c;

  always_comb begin
    char_c = lut_ascii;
    if (lut_ascii >= 8'h61 && lut_ascii <= 8'h7A && (shift_active ^ caps_q))
      char_c = lut_ascii - 8'h20;
    pop_c      = (cnt_q != '0) && ascii_ready;
    push_req_c = pend_q && (lut_ascii != 8'h00);
    // a full FIFO still accepts when the head leaves in the same cycle
    push_c     = push_req_c && ((cnt_q != FULL_CNT) || pop_c);
    cnt_d      = cnt_q;
    if (push_c && !pop_c) cnt_d = cnt_q + 1'b1;
    if (!push_c && pop_c) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      key_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[wr_q] <= char_c;
        wr_q        <= wr_q + 1'b1;
        key_count   <= key_count + 8'd1;
      end
      if (pop_c) rd_q <= rd_q + 1'b1;
      if (push_req_c && !push_c) overflow <= 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign ascii_data  = mem_q[rd_q];
  assign ascii_valid = (cnt_q != '0);

endmodule

// File: tb/tb_kb_ascii_ctrl.sv
// Bench for kb_ascii_ctrl: directed vector table, corner sequences and a
// randomized byte stream checked against a queue-based character model.
module tb_kb_ascii_ctrl;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, kb_valid, ascii_ready;
  logic [7:0] kb_data, lut_code, lut_ascii, ascii_data, key_count;
  logic       ascii_valid, shift_active, caps_active, overflow;

  always #5 clk = ~clk;

  function automatic logic [7:0] lut(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h61;
      8'h32: return 8'h62;
      8'h21: return 8'h63;
      8'h1A: return 8'h7A;
      8'h16: return 8'h31;
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  assign lut_ascii = lut(lut_code);

  kb_ascii_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_valid(kb_valid),
    .lut_code(lut_code), .lut_ascii(lut_ascii), .ascii_data(ascii_data),
    .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .shift_active(shift_active), .caps_active(caps_active),
    .key_count(key_count), .overflow(overflow)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: prefix flags, modifier bits and the expected character queue
  bit         m_ext, m_brk, m_shl, m_shr, m_caps, m_pend, m_ovf;
  logic [7:0] m_code, m_last, m_kc;
  logic [7:0] mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_pend = 0; m_ovf = 0;
    m_code = 0; m_last = 0; m_kc = 0;
    mq.delete();
  endtask

  task automatic model_byte(input logic [7:0] d);
    bit is_repeat;
`ifdef KB_TYPEMATIC_FILTER_EN
    is_repeat = (d == m_last);
`else
    is_repeat = 0;
`endif
    if (m_ext && m_brk) begin
      m_ext = 0; m_brk = 0;
    end else if (m_ext) begin
      if (d == 8'hF0) m_brk = 1; else m_ext = 0;
    end else if (m_brk) begin
      if (d == 8'h12) m_shl = 0;
      if (d == 8'h59) m_shr = 0;
      if (d == m_last) m_last = 0;
      m_brk = 0;
    end else if (d == 8'hF0) m_brk = 1;
    else if (d == 8'hE0) m_ext = 1;
    else if (!is_repeat) begin
      m_last = d;
      if (d == 8'h12) m_shl = 1;
      else if (d == 8'h59) m_shr = 1;
      else if (d == 8'h58) m_caps = !m_caps;
      else begin m_code = d; m_pend = 1; end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic [7:0] ch;
    bit pop;
    kb_valid = v; kb_data = d; ascii_ready = r;
    pop = (mq.size() > 0) && r;
    ch  = 8'h00;
    if (m_pend) begin
      ch = lut(m_code);
      if (ch >= 8'h61 && ch <= 8'h7A && ((m_shl | m_shr) ^ m_caps)) ch = ch - 8'h20;
    end
    if (pop) void'(mq.pop_front());
    if (ch != 8'h00) begin
      if (mq.size() < DEPTH) begin mq.push_back(ch); m_kc = m_kc + 8'd1; end
      else m_ovf = 1;
    end
    m_pend = 0;
    if (v) model_byte(d);
    @(posedge clk); #1;
    chk("ascii_valid", ascii_valid, mq.size() > 0);
    if (mq.size() > 0) chk("ascii_data", ascii_data, mq[0]);
    chk("key_count", key_count, m_kc);
    chk("overflow", overflow, m_ovf);
    chk("shift_active", shift_active, m_shl | m_shr);
    chk("caps_active", caps_active, m_caps);
  endtask

  task automatic do_reset();
    kb_valid = 0; kb_data = 0; ascii_ready = 0;
    rst = 1; #1;
    chk("rst ascii_valid", ascii_valid, 0);
    chk("rst ascii_data", ascii_data, 0);
    chk("rst lut_code", lut_code, 0);
    chk("rst key_count", key_count, 0);
    chk("rst overflow", overflow, 0);
    chk("rst shift_caps", {shift_active, caps_active}, 0);
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  typedef struct {
    int         op;   // 0 = apply byte/idle cycle, 1 = reset
    logic       v;
    logic [7:0] d;
    logic       es, ec;
    int         ekc;
    logic       ev;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int op, input logic v, input logic [7:0] d, input logic es,
                     input logic ec, input int ekc, input logic ev, input logic [7:0] ed);
    vec_t e;
    e.op = op; e.v = v; e.d = d; e.es = es; e.ec = ec; e.ekc = ekc; e.ev = ev; e.ed = ed;
    tbl.push_back(e);
  endtask

  logic [7:0] codes[7] = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h16, 8'h29, 8'h5A};
  logic [7:0] pool[15] = '{8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h32, 8'h21,
                           8'h1A, 8'h16, 8'h29, 8'h5A, 8'h3B, 8'h75, 8'hF0};
  logic [7:0] seq6[6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};

  initial begin
    rst = 0; kb_valid = 0; kb_data = 0; ascii_ready = 0;
    model_clear();
    #3;

    // plain 'a', then its break
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 8'h1C, 0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 1, 8'h61);
    add(0, 1, 8'hF0, 0, 0, 1, 0, 0);
    add(0, 1, 8'h1C, 0, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0);
    // shifted 'A', shift released, 'a'
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 8'h12, 1, 0, 0, 0, 0);
    add(0, 1, 8'h1C, 1, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 1, 1, 8'h41);
    add(0, 1, 8'hF0, 1, 0, 1, 0, 0);
    add(0, 1, 8'h1C, 1, 0, 1, 0, 0);
    add(0, 1, 8'hF0, 1, 0, 1, 0, 0);
    add(0, 1, 8'h12, 0, 0, 1, 0, 0);
    add(0, 1, 8'h1C, 0, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 2, 1, 8'h61);
    add(0, 0, 8'h00, 0, 0, 2, 0, 0);
    // caps on gives 'A'; caps plus shift gives 'a'
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 8'h58, 0, 1, 0, 0, 0);
    add(0, 1, 8'hF0, 0, 1, 0, 0, 0);
    add(0, 1, 8'h58, 0, 1, 0, 0, 0);
    add(0, 1, 8'h1C, 0, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 1, 1, 8'h41);
    add(0, 1, 8'h12, 1, 1, 1, 0, 0);
    add(0, 1, 8'h1C, 1, 1, 1, 0, 0);
    add(0, 0, 8'h00, 1, 1, 2, 1, 8'h61);
    add(0, 0, 8'h00, 1, 1, 2, 0, 0);
    // extended make and break produce nothing
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 8'hE0, 0, 0, 0, 0, 0);
    add(0, 1, 8'h75, 0, 0, 0, 0, 0);
    add(0, 1, 8'hE0, 0, 0, 0, 0, 0);
    add(0, 1, 8'hF0, 0, 0, 0, 0, 0);
    add(0, 1, 8'h75, 0, 0, 0, 0, 0);
    add(0, 1, 8'h1C, 0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 1, 8'h61);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].op == 1) do_reset();
      else begin
        step(tbl[i].v, tbl[i].d, 1'b1);
        chk("tbl shift", shift_active, tbl[i].es);
        chk("tbl caps", caps_active, tbl[i].ec);
        chk("tbl key_count", key_count, tbl[i].ekc);
        chk("tbl valid", ascii_valid, tbl[i].ev);
        if (tbl[i].ev) chk("tbl data", ascii_data, tbl[i].ed);
      end
    end

    // typematic repeat
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq6[i], 1'b1);
      step(1'b0, 8'h00, 1'b1);
    end
`ifdef KB_TYPEMATIC_FILTER_EN
    chk("typematic count", key_count, 2);
`else
    chk("typematic count", key_count, 4);
`endif

    // overflow on a full FIFO, then drain in order
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, codes[i % 7], 1'b0);
      step(1'b0, 8'h00, 1'b0);
    end
    chk("full key_count", key_count, 8);
    chk("full overflow", overflow, 1);
    chk("full head", ascii_data, 8'h61);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    chk("drained valid", ascii_valid, 0);
    chk("drained overflow sticky", overflow, 1);

    // reset after a break prefix: next byte decodes as a make
    do_reset();
    step(1'b1, 8'hF0, 1'b0);
    do_reset();
    step(1'b1, 8'h1C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("post-reset make valid", ascii_valid, 1);
    chk("post-reset make data", ascii_data, 8'h61);

    // randomized stream
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 2) == 0, pool[$urandom_range(0, 14)],
           (i % 400 < 300) ? ($urandom_range(0, 3) != 0) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
